// File: rtl/dmem_bridge.sv
// dmem_bridge: data-side bridge between the pipeline memory stage and a
// word-wide synchronous data bus.
//
// Ports
//   clk, reset_n         clock, synchronous active-low reset
//   req, addr, write,    memory-stage request; operands held until ack
//   data_out, extend,
//   width
//   ack, data_in         one-cycle completion pulse, extended load result
//   bus_req, bus_addr,   registered bus beat request (word aligned)
//   bus_we, bus_wstrb,
//   bus_wdata
//   bus_ack, bus_rdata   bus beat completion and read data
//
// Misaligned accesses that cross a word boundary are split into two beats
// at consecutive word addresses; read data from both beats is reassembled
// and then extended.
module dmem_bridge (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req,
  input  logic [31:0] addr,
  input  logic        write,
  input  logic [31:0] data_out,
  input  logic        extend,
  input  logic [1:0]  width,
  output logic        ack,
  output logic [31:0] data_in,
  output logic        bus_req,
  output logic [31:0] bus_addr,
  output logic        bus_we,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BEAT1 = 2'd1,
    S_BEAT2 = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t          state_q;
  logic [AW-1:0]   addr_q;
  logic            write_q;
  logic [1:0]      width_q;
  logic            extend_q;
  logic [DW-1:0]   wdata_q;
  logic [DW-1:0]   rdata1_q;
  logic            split;

  // Access size in bytes; width 3 behaves as a word.
  function automatic logic [2:0] nbytes(input logic [1:0] w);
    logic [2:0] n;
    case (w)
      2'd0:    n = 3'd1;
      2'd1:    n = 3'd2;
      default: n = 3'd4;
    endcase
    return n;
  endfunction

  // True when the access spills past the end of its word.
  function automatic logic is_split(input logic [1:0] w, input logic [1:0] o);
    return (3'({1'b0, o}) + nbytes(w)) > 3'd4;
  endfunction

  // Byte-lane strobes for beat 1 (hi = 0) or beat 2 (hi = 1).
  function automatic logic [3:0] lane_strb(input logic [1:0] w, input logic [1:0] o,
                                           input logic hi);
    logic [7:0] m;
    case (w)
      2'd0:    m = 8'h01;
      2'd1:    m = 8'h03;
      default: m = 8'h0F;
    endcase
    m = m << o;
    return hi ? m[7:4] : m[3:0];
  endfunction

  // Lane-steered write data for beat 1 (hi = 0) or beat 2 (hi = 1).
  function automatic logic [31:0] steer(input logic [31:0] d, input logic [1:0] o,
                                        input logic hi);
    logic [63:0] s;
    s = 64'(d) << {o, 3'b000};
    return hi ? s[63:32] : s[31:0];
  endfunction

  // Reassemble the addressed bytes from up to two beats, then extend.
  function automatic logic [31:0] load_result(input logic [31:0] lo, input logic [31:0] hi,
                                              input logic [1:0] o, input logic [1:0] w,
                                              input logic ext);
    logic [31:0] r;
    logic [31:0] res;
    r = 32'({hi, lo} >> {o, 3'b000});
    case (w)
      2'd0:    res = ext ? {{24{r[7]}}, r[7:0]}   : {24'h0, r[7:0]};
      2'd1:    res = ext ? {{16{r[15]}}, r[15:0]} : {16'h0, r[15:0]};
      default: res = r;
    endcase
    return res;
  endfunction

  assign split = is_split(width_q, addr_q[1:0]);

  // Access sequencer; every bus and pipeline output is a register loaded on state entry.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      write_q   <= 1'b0;
      width_q   <= 2'd0;
      extend_q  <= 1'b0;
      wdata_q   <= '0;
      rdata1_q  <= '0;
      ack       <= 1'b0;
      data_in   <= '0;
      bus_req   <= 1'b0;
      bus_addr  <= '0;
      bus_we    <= 1'b0;
      bus_wstrb <= 4'h0;
      bus_wdata <= '0;
    end else begin
      ack <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req) begin
            addr_q    <= addr;
            write_q   <= write;
            width_q   <= width;
            extend_q  <= extend;
            wdata_q   <= data_out;
            bus_req   <= 1'b1;
            bus_addr  <= {addr[31:2], 2'b00};
            bus_we    <= write;
            bus_wstrb <= write ? lane_strb(width, addr[1:0], 1'b0) : 4'h0;
            bus_wdata <= steer(data_out, addr[1:0], 1'b0);
            state_q   <= S_BEAT1;
          end
        end

        S_BEAT1: begin
          if (bus_ack) begin
            rdata1_q <= bus_rdata;
            if (split) begin
              // Second word wraps naturally at the top of the address space.
              bus_addr  <= {addr_q[31:2], 2'b00} + 32'd4;
              bus_wstrb <= write_q ? lane_strb(width_q, addr_q[1:0], 1'b1) : 4'h0;
              bus_wdata <= steer(wdata_q, addr_q[1:0], 1'b1);
              state_q   <= S_BEAT2;
            end else begin
              bus_req   <= 1'b0;
              bus_we    <= 1'b0;
              bus_wstrb <= 4'h0;
              ack       <= 1'b1;
              if (!write_q) begin
                data_in <= load_result(bus_rdata, 32'h0, addr_q[1:0], width_q, extend_q);
              end
              state_q   <= S_RESP;
            end
          end
        end

        S_BEAT2: begin
          if (bus_ack) begin
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_wstrb <= 4'h0;
            ack       <= 1'b1;
            if (!write_q) begin
              data_in <= load_result(rdata1_q, bus_rdata, addr_q[1:0], width_q, extend_q);
            end
            state_q   <= S_RESP;
          end
        end

        // req is deliberately ignored here; a still-high req restarts from IDLE.
        S_RESP: begin
          state_q <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/dmem_bridge.md
# dmem_bridge

Data-side memory bridge between the pipeline memory stage and a word-wide synchronous data bus. It consumes the memory stage's request port (req/addr/write/data_out/extend/width) and returns ack plus load data (data_in). It performs byte-lane steering, write strobes, sign/zero extension and splitting of misaligned accesses into two bus beats. The handshake to the memory stage follows a hold-until-ack rule: the stage keeps req and its operands stable until it sees ack.

## Interface
- No parameters.
- clk  input  1  clock; all state updates on rising edge.
- reset_n  input  1  synchronous, active-low reset.
- req  input  1  access request; held with operands stable until ack.
- addr  input  32  byte address.
- write  input  1  1 = store, 0 = load.
- data_out  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- extend  input  1  loads only: 1 = sign-extend, 0 = zero-extend.
- width  input  2  0 = byte, 1 = half, 2 = word, 3 = treated as word.
- ack  output  1  one-cycle completion pulse.
- data_in  output  32  extended load result; registered; valid from the ack cycle and held until the next load's ack.
- bus_req  output  1  bus beat request; held until bus_ack.
- bus_addr  output  32  word address, [1:0] = 0.
- bus_we  output  1  beat is a write.
- bus_wstrb  output  4  byte-lane write enables; 0 on reads.
- bus_wdata  output  32  lane-steered write data.
- bus_ack  input  1  beat complete; may arrive in the first cycle of bus_req.
- bus_rdata  input  32  read data, valid when bus_ack = 1.

## Operation
- Offset o = addr[1:0]. Byte count n = 1, 2 or 4 from width.
- Split rule: if o + n > 4, the access takes two beats: beat 1 at {addr[31:2],2'b00}, beat 2 at that address + 4. The address wraps mod 2^32, so 0xFFFFFFFC + 4 = 0x00000000.
- Strobes: mask = ((1<<n)-1) << o, taken as 8 bits. Beat 1 uses mask[3:0]; beat 2 uses mask[7:4].
- Write data: the 64-bit value {32'b0,data_out} << 8·o. Beat 1 drives bits [31:0]; beat 2 drives bits [63:32].
- Read assembly: R = ({beat2_rdata, beat1_rdata} >> 8·o)[31:0]; for single-beat loads beat2_rdata = 0. Keep the low n bytes, then extend from bit 8n−1 according to extend.
- Stores leave data_in unchanged.
- FSM states:
  - IDLE: bus_req = 0. If req = 1, latch addr, write, width, extend and data_out, then go to BEAT1.
  - BEAT1: bus_req = 1 with beat-1 fields. On bus_ack, capture bus_rdata, then go to BEAT2 if split, else RESP.
  - BEAT2: bus_req = 1 with beat-2 fields. On bus_ack, go to RESP.
  - RESP: ack = 1; data_in is updated on entry for loads. Always go to IDLE, and ignore req in this cycle.
- Because req is ignored in RESP, a req still high in the cycle after ack (e.g. the stage is held by writeback stall) is re-executed as a new access. Repeated loads and stores are idempotent; this is the intended behaviour.
- Operand changes while not in IDLE are ignored; the latched copies are used.

## Timing
- Reset (reset_n = 0 at an edge):
  - state = IDLE, ack = 0, data_in = 0, bus_req = 0, bus_we = 0, bus_wstrb = 0, bus_addr = 0, bus_wdata = 0.
  - Reset takes effect from any state; an outstanding bus beat is abandoned.
  - The bus must tolerate bus_req dropping before bus_ack.
- Bus outputs are registered and change only on state entry. With zero-wait bus_ack:
  - Single beat: req sampled in cycle N, bus_req in N+1, ack in N+2.
  - Split access: ack in N+3.
  - Each bus wait cycle adds one cycle.
- Minimum spacing is 3 cycles per single-beat access (IDLE, BEAT1, RESP).
- ack is high for exactly one cycle per accepted request.
- data_in changes only at entry to RESP for loads.

## Test plan
- Aligned word load, addr 0x100, bus_rdata 0xDEADBEEF, zero wait:
  - bus_req/bus_addr = 0x100 one cycle after req; ack two cycles after req; data_in = 0xDEADBEEF.
  - data_in held across a following store.
- Byte loads from word 0x80F01234:
  - addr 0x203, extend = 1 → data_in = 0xFFFFFF80.
  - Same access with extend = 0 → data_in = 0x00000080.
- Half store at addr 0x102, data_out 0x0000ABCD:
  - Single beat, bus_addr 0x100, bus_wstrb 4'b1100, bus_wdata[31:16] = 0xABCD; ack follows.
- Misaligned word load, addr 0x0FFFFFFD, rdata 0x11223344 then 0x55667788:
  - Beats at 0x0FFFFFFC and 0x10000000; data_in = 0x88112233.
  - Repeat at addr 0xFFFFFFFF: beat 2 address wraps to 0x00000000.
- Misaligned word store, addr 0x201, data_out 0xA1B2C3D4, bus_ack delayed 2 cycles per beat:
  - Beat 1: strobe 1110, wdata 0xB2C3D400.
  - Beat 2: strobe 0001, wdata 0x000000A1.
  - ack 7 cycles after req.
- Reset mid-access during BEAT2, and req held high through ack:
  - Reset: all outputs return to reset values next cycle.
  - req held through ack: req ignored in RESP, re-issued from IDLE.
